// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - run-word driven sequencer for the user-domain readout datapath
module run_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int DRAIN_TIMEOUT = 1024,
   parameter int TS_W          = 32
) (
   input  logic            user_clk,
   input  logic            user_rst,
   input  logic [31:0]     run_word,
   input  logic            pps_in,
   input  logic            dp_busy,
   output logic            dp_rst,
   output logic            dp_en,
   output logic [TS_W-1:0] ts,
   output logic [7:0]      run_id,
   output logic [31:0]     status
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARM      = 3'd1,
      WAIT_PPS = 3'd2,
      RUN      = 3'd3,
      DRAIN    = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t          state, state_n;
   logic [31:0]     cnt, cnt_n;
   logic [TS_W-1:0] ts_n;
   logic [7:0]      run_id_n;
   logic            timeout_flag, timeout_n;
   logic            pps_seen, pps_seen_n;
   logic            dp_rst_n, dp_en_n;
   logic [31:0]     status_n;

   logic [2:0]      rw_q;
   logic            clr_prev;
   logic            pps_s1, pps_s2, pps_s3, pps_rise;
   logic            run_en, pps_sync, clr_rise;
   logic            unused_run_bits;

   assign unused_run_bits = ^run_word[31:3];
   assign run_en   = rw_q[0];
   assign pps_sync = rw_q[1];
   assign clr_rise = rw_q[2] & ~clr_prev;

   // Input capture: run word registered once, PPS through two sync flops then a registered edge
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         rw_q     <= 3'b000;
         clr_prev <= 1'b0;
         pps_s1   <= 1'b0;
         pps_s2   <= 1'b0;
         pps_s3   <= 1'b0;
         pps_rise <= 1'b0;
      end else begin
         rw_q     <= run_word[2:0];
         clr_prev <= rw_q[2];
         pps_s1   <= pps_in;
         pps_s2   <= pps_s1;
         pps_s3   <= pps_s2;
         pps_rise <= pps_s2 & ~pps_s3;
      end
   end

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state        <= IDLE;
         cnt          <= 32'd0;
         ts           <= '0;
         run_id       <= 8'd0;
         timeout_flag <= 1'b0;
         pps_seen     <= 1'b0;
         dp_rst       <= 1'b1;
         dp_en        <= 1'b0;
         status       <= 32'd0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         ts           <= ts_n;
         run_id       <= run_id_n;
         timeout_flag <= timeout_n;
         pps_seen     <= pps_seen_n;
         dp_rst       <= dp_rst_n;
         dp_en        <= dp_en_n;
         status       <= status_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      ts_n       = ts;
      run_id_n   = run_id;
      timeout_n  = timeout_flag;
      pps_seen_n = pps_seen;
      case (state)
         IDLE: begin
            ts_n = '0;
            if (run_en) begin
               state_n = ARM;
               cnt_n   = 32'(RST_CYCLES - 1);
            end
         end
         ARM: begin
            if (cnt == 32'd0) state_n = pps_sync ? WAIT_PPS : RUN;
            else              cnt_n   = cnt - 32'd1;
         end
         WAIT_PPS: begin
            // Dropping run_en takes priority over a coincident PPS edge
            if (!run_en) state_n = IDLE;
            else if (pps_rise) begin
               state_n    = RUN;
               pps_seen_n = 1'b1;
            end
         end
         RUN: begin
            ts_n = ts + TS_W'(1);
            if (!run_en) begin
               state_n = DRAIN;
               cnt_n   = 32'(DRAIN_TIMEOUT - 1);
            end
         end
         DRAIN: begin
            if (!dp_busy) state_n = DONE;
            else if (cnt == 32'd0) begin
               state_n   = DONE;
               timeout_n = 1'b1;
            end else cnt_n = cnt - 32'd1;
         end
         DONE: begin
            run_id_n = run_id + 8'd1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (clr_rise) begin
         timeout_n  = 1'b0;
         pps_seen_n = 1'b0;
         run_id_n   = 8'd0;
      end
      dp_rst_n = (state_n == IDLE) || (state_n == ARM);
      dp_en_n  = (state_n == RUN);
      status_n = {16'h0000, run_id_n, 3'b000, pps_seen_n, timeout_n, state_n};
   end

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - directed vector bench for run_sequencer
module tb_run_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] run_word;
   logic        pps_in;
   logic        dp_busy;

   logic        a_dp_rst, a_dp_en;
   logic [31:0] a_ts;
   logic [7:0]  a_run_id;
   logic [31:0] a_status;

   logic        b_dp_rst, b_dp_en;
   logic [7:0]  b_ts;
   logic [7:0]  b_run_id;
   logic [31:0] b_status;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   run_sequencer #(.RST_CYCLES(16), .DRAIN_TIMEOUT(1024), .TS_W(32)) dut_a (
      .user_clk(clk), .user_rst(rst), .run_word(run_word), .pps_in(pps_in), .dp_busy(dp_busy),
      .dp_rst(a_dp_rst), .dp_en(a_dp_en), .ts(a_ts), .run_id(a_run_id), .status(a_status)
   );

   run_sequencer #(.RST_CYCLES(16), .DRAIN_TIMEOUT(8), .TS_W(8)) dut_b (
      .user_clk(clk), .user_rst(rst), .run_word(run_word), .pps_in(pps_in), .dp_busy(dp_busy),
      .dp_rst(b_dp_rst), .dp_en(b_dp_en), .ts(b_ts), .run_id(b_run_id), .status(b_status)
   );

   typedef struct {
      int          n;
      logic [31:0] rw;
      logic        busy;
      logic        exp_rst;
      logic        exp_en;
      logic [31:0] exp_ts;
      logic [31:0] exp_status;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      run_word = 32'd0;
      pps_in   = 1'b0;
      dp_busy  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      // n, run_word, busy, dp_rst, dp_en, ts, status
      tbl[0]  = '{1,   32'd1, 1'b1, 1'b1, 1'b0, 32'd0,   32'h000};
      tbl[1]  = '{1,   32'd1, 1'b1, 1'b1, 1'b0, 32'd0,   32'h001};
      tbl[2]  = '{15,  32'd1, 1'b1, 1'b1, 1'b0, 32'd0,   32'h001};
      tbl[3]  = '{1,   32'd1, 1'b1, 1'b0, 1'b1, 32'd0,   32'h003};
      tbl[4]  = '{100, 32'd1, 1'b1, 1'b0, 1'b1, 32'd100, 32'h003};
      tbl[5]  = '{1,   32'd0, 1'b1, 1'b0, 1'b1, 32'd101, 32'h003};
      tbl[6]  = '{1,   32'd0, 1'b1, 1'b0, 1'b0, 32'd102, 32'h004};
      tbl[7]  = '{9,   32'd0, 1'b1, 1'b0, 1'b0, 32'd102, 32'h004};
      tbl[8]  = '{1,   32'd0, 1'b0, 1'b0, 1'b0, 32'd102, 32'h005};
      tbl[9]  = '{1,   32'd0, 1'b0, 1'b1, 1'b0, 32'd102, 32'h100};
      tbl[10] = '{1,   32'd0, 1'b0, 1'b1, 1'b0, 32'd0,   32'h100};

      do_reset();
      chk("reset a dp_rst", {31'd0, a_dp_rst}, 32'd1);
      chk("reset a dp_en", {31'd0, a_dp_en}, 32'd0);
      chk("reset a ts", a_ts, 32'd0);
      chk("reset a status", a_status, 32'd0);
      chk("reset b status", b_status, 32'd0);

      // Plain run, drain with dp_busy released after 10 cycles
      for (int i = 0; i < 11; i++) begin
         run_word = tbl[i].rw;
         dp_busy  = tbl[i].busy;
         tick(tbl[i].n);
         chk($sformatf("vec%0d dp_rst", i), {31'd0, a_dp_rst}, {31'd0, tbl[i].exp_rst});
         chk($sformatf("vec%0d dp_en", i), {31'd0, a_dp_en}, {31'd0, tbl[i].exp_en});
         chk($sformatf("vec%0d ts", i), a_ts, tbl[i].exp_ts);
         chk($sformatf("vec%0d status", i), a_status, tbl[i].exp_status);
      end
      chk("run_id after run", {24'd0, a_run_id}, 32'd1);

      // PPS-aligned start: pin edge 50 cycles after ARM exit
      do_reset();
      run_word = 32'd3;
      dp_busy  = 1'b1;
      tick(18);
      chk("pps wait state", a_status, 32'h002);
      chk("pps wait dp_rst", {31'd0, a_dp_rst}, 32'd0);
      tick(49);
      pps_in = 1'b1;
      tick(3);
      chk("pps pre-rise status", a_status, 32'h002);
      chk("pps pre-rise dp_en", {31'd0, a_dp_en}, 32'd0);
      tick(1);
      chk("pps run status", a_status, 32'h013);
      chk("pps run dp_en", {31'd0, a_dp_en}, 32'd1);
      pps_in = 1'b0;

      // run_en dropped in WAIT_PPS coincident with pps_rise
      do_reset();
      run_word = 32'd3;
      tick(18);
      chk("abort wait state", a_status, 32'h002);
      pps_in = 1'b1;
      tick(2);
      run_word = 32'd2;
      tick(1);
      chk("abort pre status", a_status, 32'h002);
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk($sformatf("abort dp_en t%0d", i), {31'd0, a_dp_en}, 32'd0);
         chk($sformatf("abort status t%0d", i), a_status, 32'h000);
      end
      pps_in = 1'b0;

      // Drain timeout with DRAIN_TIMEOUT=8, then clr
      do_reset();
      run_word = 32'd1;
      dp_busy  = 1'b1;
      tick(20);
      chk("tmo run status", b_status, 32'h003);
      run_word = 32'd0;
      tick(2);
      chk("tmo drain status", b_status, 32'h004);
      chk("tmo drain dp_en", {31'd0, b_dp_en}, 32'd0);
      tick(7);
      chk("tmo last drain status", b_status, 32'h004);
      tick(1);
      chk("tmo done status", b_status, 32'h00D);
      tick(1);
      chk("tmo idle status", b_status, 32'h108);
      chk("tmo run_id", {24'd0, b_run_id}, 32'd1);
      run_word = 32'd4;
      tick(2);
      chk("clr status", b_status, 32'h000);
      chk("clr run_id", {24'd0, b_run_id}, 32'd0);

      // 8-bit timestamp wrap, then async reset mid-RUN
      do_reset();
      run_word = 32'd1;
      tick(18);
      chk("wrap start ts", {24'd0, b_ts}, 32'd0);
      tick(300);
      chk("wrap ts", {24'd0, b_ts}, 32'd44);
      chk("wrap status", b_status, 32'h003);
      rst = 1'b1;
      #1;
      chk("async rst dp_en", {31'd0, b_dp_en}, 32'd0);
      chk("async rst dp_rst", {31'd0, b_dp_rst}, 32'd1);
      chk("async rst ts", {24'd0, b_ts}, 32'd0);
      chk("async rst status", b_status, 32'h000);
      chk("async rst a dp_en", {31'd0, a_dp_en}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
